addr_stp_collect: RTL and testbench

// Downstream stage of the burst control block: consumes the serial address stream (burst-generated or external

---
 rtl/addr_stp_collect.sv | 141 ++++++++++++++
 tb/tb_addr_stp_collect.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_stp_collect.sv
// Serial-to-parallel address collector.
// Picks the burst or the external serial address bit with addr_sel and shifts
// it in MSB-first. Each finished word goes into an output register and is
// offered downstream over a valid/ready handshake. A frame that completes
// while the output register is still full is dropped, flagged and counted.
//
// Handshake: the consumer takes addr_out on a rising edge where both
// addr_valid and addr_ready are 1. While addr_valid is 1 and no transfer has
// happened, addr_out holds its value. addr_valid falls only after a transfer
// or a reset. addr_ready has no effect while addr_valid is 0.
module addr_stp_collect #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              addr_sel,
    input  logic              addr_burst_in,
    input  logic              addr_ext_in,
    input  logic              ser_en,
    input  logic              frame_clr,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              busy,
    output logic              overrun,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  ovr_cnt,
    output logic [1:0]        dbg_state
);

    // The bit counter only has to reach ADDR_W-1. On the ADDR_W-th bit it
    // wraps straight back to 0.
    localparam int CW = (ADDR_W <= 2) ? 1 : $clog2(ADDR_W);
    localparam logic [CW-1:0] LAST_IDX = CW'(ADDR_W - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } shift_state_t;

    typedef enum logic {
        O_EMPTY = 1'b0,
        O_FULL  = 1'b1
    } out_state_t;

    shift_state_t      r_sstate;
    out_state_t        r_ostate;
    logic [CW-1:0]     r_cnt;
    logic [ADDR_W-1:0] r_sh;
    logic              r_busy;
    logic [ADDR_W-1:0] r_addr;
    logic              r_ovr;
    logic [CNT_W-1:0]  r_word_cnt;
    logic [CNT_W-1:0]  r_ovr_cnt;

    logic              w_bit;
    logic              w_take;
    logic              w_done;
    logic              w_accept;
    logic [ADDR_W-1:0] w_word;

    // Select one of the two serial sources on every cycle, then decode the
    // conditions for this edge.
    always_comb begin
        w_bit    = addr_sel ? addr_burst_in : addr_ext_in;
        // frame_clr wins over ser_en, so a bit that arrives with it is lost.
        w_take   = ser_en & ~frame_clr;
        w_done   = w_take & (r_cnt == LAST_IDX);
        w_accept = (r_ostate == O_FULL) & addr_ready;
        // The finished word includes the bit sampled on this same edge.
        w_word   = {r_sh[ADDR_W-2:0], w_bit};
    end

    // Shift FSM: IDLE when no bits are held, SHIFT while a frame is partly
    // received. busy is registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sstate <= S_IDLE;
            r_cnt    <= '0;
            r_sh     <= '0;
            r_busy   <= 1'b0;
        end else if (frame_clr) begin
            r_sstate <= S_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (ser_en) begin
            r_sh <= w_word;
            if (r_cnt == LAST_IDX) begin
                r_sstate <= S_IDLE;
                r_cnt    <= '0;
                r_busy   <= 1'b0;
            end else begin
                r_sstate <= S_SHIFT;
                r_cnt    <= r_cnt + CW'(1);
                r_busy   <= 1'b1;
            end
        end
    end

    // Output-register FSM: EMPTY/FULL, with the delivery counter, the drop
    // counter and the sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ostate   <= O_EMPTY;
            r_addr     <= '0;
            r_ovr      <= 1'b0;
            r_word_cnt <= '0;
            r_ovr_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_ostate   <= O_EMPTY;
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
            if (w_done) begin
                if ((r_ostate == O_EMPTY) || w_accept) begin
                    // A transfer on this edge frees the register in time for
                    // the new word.
                    r_addr   <= w_word;
                    r_ostate <= O_FULL;
                end else begin
                    // The output is full and held: drop the new frame and keep
                    // the word the consumer has not taken yet.
                    r_ovr <= 1'b1;
                    if (r_ovr_cnt != {CNT_W{1'b1}}) begin
                        r_ovr_cnt <= r_ovr_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign addr_out   = r_addr;
    assign addr_valid = (r_ostate == O_FULL);
    assign busy       = r_busy;
    assign overrun    = r_ovr;
    assign word_cnt   = r_word_cnt;
    assign ovr_cnt    = r_ovr_cnt;
    assign dbg_state  = {r_ostate == O_FULL, r_sstate == S_SHIFT};

endmodule

// File: tb/tb_addr_stp_collect.sv
// Bench for addr_stp_collect: directed scenarios with literal expectations,
// then a randomized phase. An arithmetic reference model is compared with the
// DUT on every cycle.
module tb_addr_stp_collect;

  localparam int W  = 10;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          addr_sel = 1'b0;
  logic          addr_burst_in = 1'b0;
  logic          addr_ext_in = 1'b0;
  logic          ser_en = 1'b0;
  logic          frame_clr = 1'b0;
  logic          addr_ready = 1'b0;
  logic [W-1:0]  addr_out;
  logic          addr_valid;
  logic          busy;
  logic          overrun;
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] ovr_cnt;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;
  bit ready_lvl = 1'b0;

  addr_stp_collect #(.ADDR_W(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .addr_sel(addr_sel), .addr_burst_in(addr_burst_in),
    .addr_ext_in(addr_ext_in), .ser_en(ser_en), .frame_clr(frame_clr),
    .addr_out(addr_out), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .busy(busy), .overrun(overrun), .word_cnt(word_cnt), .ovr_cnt(ovr_cnt),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: bits are counted arithmetically and words are formed as
  // acc*2+bit
  int m_cnt = 0;
  int m_acc = 0;
  int m_out = 0;
  int m_valid = 0;
  int m_ovr = 0;
  int m_wc = 0;
  int m_oc = 0;

  always @(posedge clk) begin
    int b;
    int acc_now;
    bit done;
    bit take;
    b = addr_sel ? int'(addr_burst_in) : int'(addr_ext_in);
    if (rst) begin
      m_cnt = 0; m_acc = 0; m_out = 0; m_valid = 0; m_ovr = 0; m_wc = 0; m_oc = 0;
    end else begin
      done = 1'b0;
      take = (m_valid != 0) && addr_ready;
      if (frame_clr) begin
        m_cnt = 0;
      end else if (ser_en) begin
        m_acc = (m_acc * 2 + b) % (1 << W);
        m_cnt = m_cnt + 1;
        if (m_cnt == W) begin
          done = 1'b1;
          m_cnt = 0;
        end
      end
      acc_now = m_acc;
      if (take) begin
        m_valid = 0;
        m_wc = (m_wc + 1) % (1 << CW);
      end
      if (done) begin
        if (m_valid == 0) begin
          m_out = acc_now;
          m_valid = 1;
        end else begin
          m_ovr = 1;
          if (m_oc < (1 << CW) - 1) m_oc = m_oc + 1;
        end
      end
    end
  end

  // scoreboard check
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // cycle-by-cycle comparison with the model, on the inactive clock edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_addr_out",   32'(addr_out),   32'(m_out));
      check("m_addr_valid", 32'(addr_valid), 32'(m_valid));
      check("m_busy",       32'(busy),       32'(m_cnt != 0));
      check("m_overrun",    32'(overrun),    32'(m_ovr));
      check("m_word_cnt",   32'(word_cnt),   32'(m_wc));
      check("m_ovr_cnt",    32'(ovr_cnt),    32'(m_oc));
    end
  end

  // driver tasks
  task automatic noise();
    addr_burst_in = 1'($urandom_range(0, 1));
    addr_ext_in   = 1'($urandom_range(0, 1));
    addr_sel      = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
      noise();
      ser_en = 1'b0; frame_clr = 1'b0; rst = 1'b0;
      addr_ready = ready_lvl;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1; ser_en = 1'b0; frame_clr = 1'b0; addr_ready = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0; addr_ready = ready_lvl;
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int nbits, input logic sel,
                           input int gap, input bit pulse_last);
    logic [W-1:0] wv;
    wv = w;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); #1;
      rst = 1'b0; frame_clr = 1'b0; ser_en = 1'b1; addr_sel = sel;
      if (sel) begin
        addr_burst_in = wv[W-1-i];
        addr_ext_in   = 1'($urandom_range(0, 1));
      end else begin
        addr_ext_in   = wv[W-1-i];
        addr_burst_in = 1'($urandom_range(0, 1));
      end
      addr_ready = (pulse_last && i == nbits - 1) ? 1'b1 : ready_lvl;
      if (gap > 0) idle(gap);
    end
  endtask

  initial begin
    // reset state
    ready_lvl = 1'b0;
    do_reset();
    cmp_en = 1'b1;
    check("rst_valid", 32'(addr_valid), 32'd0);
    check("rst_out",   32'(addr_out),   32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_wc",    32'(word_cnt),   32'd0);

    // reset in the middle of a frame while a word is pending
    send_bits(10'h123, W, 1'b1, 0, 1'b0);
    send_bits(10'h2A5, 5, 1'b0, 0, 1'b0);
    idle(1);
    check("mid_pending", 32'(addr_valid), 32'd1);
    check("mid_busy",    32'(busy),       32'd1);
    do_reset();
    check("mid_rst_valid", 32'(addr_valid), 32'd0);
    check("mid_rst_out",   32'(addr_out),   32'd0);
    check("mid_rst_busy",  32'(busy),       32'd0);
    send_bits(10'h2A5, W, 1'b0, 0, 1'b0);
    idle(1);
    check("mid_new_out",   32'(addr_out),   32'h2A5);
    check("mid_new_valid", 32'(addr_valid), 32'd1);

    // burst source, consumer always ready
    ready_lvl = 1'b1;
    do_reset();
    send_bits(10'h3C1, W, 1'b1, 0, 1'b0);
    idle(1);
    check("burst_valid", 32'(addr_valid), 32'd1);
    check("burst_out",   32'(addr_out),   32'h3C1);
    check("burst_busy",  32'(busy),       32'd0);
    idle(1);
    check("burst_acc_valid", 32'(addr_valid), 32'd0);
    check("burst_wc",        32'(word_cnt),   32'd1);

    // external source with idle gaps; word is held until the consumer is ready
    ready_lvl = 1'b0;
    do_reset();
    send_bits(10'h155, W, 1'b0, 2, 1'b0);
    idle(20);
    check("gap_out",   32'(addr_out),   32'h155);
    check("gap_valid", 32'(addr_valid), 32'd1);
    ready_lvl = 1'b1;
    idle(1);
    ready_lvl = 1'b0;
    idle(1);
    check("gap_acc_valid", 32'(addr_valid), 32'd0);
    check("gap_wc",        32'(word_cnt),   32'd1);

    // overrun, then a transfer on the same edge as a new frame completes
    do_reset();
    send_bits(10'h001, W, 1'b1, 0, 1'b0);
    send_bits(10'h3FF, W, 1'b0, 0, 1'b0);
    idle(1);
    check("ovr_out",  32'(addr_out), 32'h001);
    check("ovr_flag", 32'(overrun),  32'd1);
    check("ovr_cnt",  32'(ovr_cnt),  32'd1);
    send_bits(10'h2B3, W, 1'b1, 0, 1'b1);
    idle(1);
    check("ovr_third_out",   32'(addr_out),   32'h2B3);
    check("ovr_third_valid", 32'(addr_valid), 32'd1);
    check("ovr_third_wc",    32'(word_cnt),   32'd1);
    check("ovr_sticky",      32'(overrun),    32'd1);

    // frame_clr in the same cycle as ser_en discards the partial frame
    do_reset();
    send_bits(10'h2FF, 4, 1'b0, 0, 1'b0);
    @(negedge clk); #1;
    ser_en = 1'b1; frame_clr = 1'b1;
    idle(1);
    check("clr_busy", 32'(busy), 32'd0);
    send_bits(10'h0AA, W, 1'b1, 0, 1'b0);
    idle(1);
    check("clr_out", 32'(addr_out), 32'h0AA);

    // 256 back-to-back frames: the delivery counter wraps
    ready_lvl = 1'b1;
    do_reset();
    for (int f = 0; f < 256; f++) begin
      send_bits(W'($urandom_range(0, (1 << W) - 1)), W, 1'($urandom_range(0, 1)), 0, 1'b0);
    end
    idle(2);
    check("wrap_wc",  32'(word_cnt), 32'd0);
    check("wrap_ovr", 32'(overrun),  32'd0);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      noise();
      rst        = ($urandom_range(0, 299) == 0);
      ser_en     = ($urandom_range(0, 3) != 0);
      frame_clr  = ($urandom_range(0, 39) == 0);
      addr_ready = ($urandom_range(0, 2) == 0);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
